// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// Holds the state encoding, default RAM geometry and the latched-command layout.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RDWAIT = 2'd3
    } arb_state_e;

    // Latched command for the default 32x8 geometry; winner index covers up to 8 requesters.
    typedef struct packed {
        logic                  we;
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
        logic [2:0]            idx;
    } arb_cmd_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection: one-hot grant from the request vector.
// RAM_ARB_RR_EN selects round-robin from ptr+1; otherwise the lowest index wins.
module ram_arb_pick import ram_arb_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

`ifdef RAM_ARB_RR_EN
    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Walk downward so the lowest requesting index is the last one written.
    always_comb begin
        grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises NUM_REQ read/write commands onto one single-port RAM; all outputs are flops.
// Define RAM_ARB_RR_EN for round-robin arbitration, otherwise fixed lowest-index priority.
module ram_port_arbiter import ram_arb_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      write_en,
    output logic                      read_en,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         data_in,
    input  logic [DATA_W-1:0]         data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_WR     = WR;
    localparam logic [1:0] S_RD     = RD;
    localparam logic [1:0] S_RDWAIT = RDWAIT;

    logic [1:0]         state;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cmd_idx;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    ram_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick)
    );

    always_comb begin
        pick_idx  = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx  = IDX_W'(i);
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RAM_ARB_RR_EN
    // Pointer moves on the grant cycle itself, i.e. while in WR or RD.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (state == S_WR || state == S_RD) begin
            ptr <= cmd_idx;
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cmd_idx  <= '0;
            cnt      <= '0;
            gnt      <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            write_en <= 1'b0;
            read_en  <= 1'b0;
            addr     <= '0;
            data_in  <= '0;
        end else begin
            gnt      <= '0;
            rvalid   <= '0;
            write_en <= 1'b0;
            read_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Strobes and grant are loaded here so they are flops during WR/RD.
                    if (|req) begin
                        cmd_idx <= pick_idx;
                        gnt     <= pick;
                        busy    <= 1'b1;
                        addr    <= sel_addr;
                        if (sel_we) begin
                            state    <= S_WR;
                            write_en <= 1'b1;
                            data_in  <= sel_wdata;
                        end else begin
                            state   <= S_RD;
                            read_en <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_RD: begin
                    state <= S_RDWAIT;
                    cnt   <= CNT_W'(RD_LAT);
                end
                S_RDWAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        rvalid <= NUM_REQ'(1) << cmd_idx;
                        rdata  <= data_out;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
